// File: rtl/imem_bridge_pkg.sv
// Shared widths, strobe polarities, stall encodings and FSM states for the instruction SRAM bridge.
// No logic here, so no latency of its own.
// No flow control here either; the stall encoding is the only backpressure the bridge has.
package imem_bridge_pkg;

  localparam int REG_BUS       = 32;
  localparam int INST_ADDR_BUS = 32;
  localparam int INST_BUS      = 32;

  // The SRAM strobes are active-low, so "enable" is the low level.
  localparam logic CHIP_ENABLE  = 1'b0;
  localparam logic CHIP_DISABLE = 1'b1;

  localparam logic STOP   = 1'b1;
  localparam logic NOSTOP = 1'b0;

  localparam logic [INST_BUS-1:0] NOP_INST = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/imem_bridge.sv
// Instruction fetch bridge: one-entry buffer in front of a 16-bit async SRAM, two reads per word.
// Latency: a hit answers in the same cycle; a miss stalls for 2*WAIT_CYCLES+3 cycles.
// Backpressure: stallreq_if holds the pipeline while ice=1 and the buffer misses; a fill is never aborted.
module imem_bridge
  import imem_bridge_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int SRAM_AW     = 20
) (
  input  logic                     cpu_clk_50M,
  input  logic                     cpu_rst_n,
  input  logic                     ice,
  input  logic [INST_ADDR_BUS-1:0] iaddr,
  output logic [INST_BUS-1:0]      inst,
  output logic                     stallreq_if,
  output logic                     sram_ce_n,
  output logic                     sram_oe_n,
  output logic [SRAM_AW-1:0]       sram_addr,
  input  logic [15:0]              sram_data
);

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  fetch_state_t        state;
  fetch_state_t        state_nxt;
  logic [29:0]         fetch_q;
  logic [29:0]         tag_q;
  logic                valid_q;
  logic [REG_BUS-1:0]  data_q;
  logic [3:0]          cnt_q;
  logic [SRAM_AW-1:0]  addr_q;
  logic                hit;
  logic                phase_done;
  logic                start_fill;
  logic                unused_addr_bits;

  // Instruction addresses are word aligned; the byte offset carries no information.
  assign unused_addr_bits = ^iaddr[1:0];

  assign hit        = (state == ST_IDLE) && ice && valid_q && (tag_q == iaddr[31:2]);
  assign phase_done = (cnt_q == WAIT_LAST);
  assign sram_addr  = addr_q;

  // State register.
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  // Next state, strobes and pipeline-facing outputs; everything stays quiet while in reset.
  always_comb begin
    state_nxt   = state;
    inst        = NOP_INST;
    stallreq_if = NOSTOP;
    sram_ce_n   = CHIP_DISABLE;
    sram_oe_n   = CHIP_DISABLE;
    start_fill  = 1'b0;
    if (cpu_rst_n) begin
      case (state)
        ST_IDLE: begin
          if (hit) begin
            inst = data_q;
          end else if (ice) begin
            stallreq_if = STOP;
            start_fill  = 1'b1;
            state_nxt   = ST_LO;
          end
        end
        ST_LO: begin
          sram_ce_n   = CHIP_ENABLE;
          sram_oe_n   = CHIP_ENABLE;
          stallreq_if = ice ? STOP : NOSTOP;
          if (phase_done) state_nxt = ST_HI;
        end
        ST_HI: begin
          sram_ce_n   = CHIP_ENABLE;
          sram_oe_n   = CHIP_ENABLE;
          stallreq_if = ice ? STOP : NOSTOP;
          if (phase_done) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Fill datapath: latch the miss address, count wait states, assemble the word low half first.
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      fetch_q <= '0;
      tag_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_fill) begin
            fetch_q <= iaddr[31:2];
            valid_q <= 1'b0;
            cnt_q   <= '0;
            addr_q  <= {iaddr[SRAM_AW:2], 1'b0};
          end
        end
        ST_LO: begin
          if (phase_done) begin
            data_q[15:0] <= sram_data;
            cnt_q        <= '0;
            addr_q       <= {fetch_q[SRAM_AW-2:0], 1'b1};
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        ST_HI: begin
          if (phase_done) begin
            data_q[31:16] <= sram_data;
            tag_q         <= fetch_q;
            valid_q       <= 1'b1;
            cnt_q         <= '0;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        default: cnt_q <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_bridge.sv
// Bench for imem_bridge: two instances (WAIT_CYCLES=2 and 0) sharing one SRAM image.
// Latency expectations are hand-computed per directed fetch and queued with the expected word.
// A negedge monitor pops deliveries and SRAM address phases from the queues and compares them.
module tb_imem_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;

  logic        ice_a, ice_b;
  logic [31:0] iaddr_a, iaddr_b;
  logic [31:0] inst_a, inst_b;
  logic        stall_a, stall_b;
  logic        ce_n_a, ce_n_b, oe_n_a, oe_n_b;
  logic [19:0] addr_a, addr_b;
  logic [15:0] data_a, data_b;

  logic [15:0] mem [64];

  int pass_cnt  = 0;
  int total_cnt = 0;
  int done_cnt  = 0;

  logic [31:0] exp_inst_q [$];
  int          exp_stall_q [$];
  int          exp_addr_q  [$];

  always #10 clk = ~clk;

  assign data_a = mem[addr_a[5:0]];
  assign data_b = mem[addr_b[5:0]];

  imem_bridge #(.WAIT_CYCLES(2), .SRAM_AW(20)) dut_a (
    .cpu_clk_50M(clk), .cpu_rst_n(rst_n), .ice(ice_a), .iaddr(iaddr_a),
    .inst(inst_a), .stallreq_if(stall_a), .sram_ce_n(ce_n_a), .sram_oe_n(oe_n_a),
    .sram_addr(addr_a), .sram_data(data_a)
  );

  imem_bridge #(.WAIT_CYCLES(0), .SRAM_AW(20)) dut_b (
    .cpu_clk_50M(clk), .cpu_rst_n(rst_n), .ice(ice_b), .iaddr(iaddr_b),
    .inst(inst_b), .stallreq_if(stall_b), .sram_ce_n(ce_n_b), .sram_oe_n(oe_n_b),
    .sram_addr(addr_b), .sram_data(data_b)
  );

  // The monitor watches whichever instance is under test.
  logic        m_ice, m_stall, m_ce_n;
  logic [31:0] m_inst;
  logic [19:0] m_addr;
  assign m_ice   = sel ? ice_b   : ice_a;
  assign m_stall = sel ? stall_b : stall_a;
  assign m_ce_n  = sel ? ce_n_b  : ce_n_a;
  assign m_inst  = sel ? inst_b  : inst_a;
  assign m_addr  = sel ? addr_b  : addr_a;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total_cnt++;
    if (act === want) pass_cnt++;
    else $display("FAIL %s: got %h, want %h", name, act, want);
  endtask

  // Scoreboard monitor.
  int          run = 0;
  logic        prev_ce_n = 1'b1;
  logic [19:0] prev_addr = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_inst", m_inst, 32'h0);
      chk("reset_stall", {31'b0, m_stall}, 32'h0);
      run       = 0;
      prev_ce_n = 1'b1;
    end else begin
      if (!m_ice) begin
        chk("ice0_inst", m_inst, 32'h0);
        chk("ice0_stall", {31'b0, m_stall}, 32'h0);
      end else if (m_stall) begin
        run++;
      end else if (exp_inst_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_delivery: got %h, want none", m_inst);
      end else begin
        chk("inst", m_inst, exp_inst_q.pop_front());
        chk("stall_cycles", run, exp_stall_q.pop_front());
        run = 0;
        done_cnt++;
      end
      if (!m_ce_n && (prev_ce_n || m_addr != prev_addr)) begin
        if (exp_addr_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_sram_access: got addr %h, want none", m_addr);
        end else begin
          chk("sram_addr", {12'b0, m_addr}, exp_addr_q.pop_front());
        end
      end
      prev_ce_n = m_ce_n;
      prev_addr = m_addr;
    end
  end

  task automatic set_in(input logic e, input logic [31:0] a);
    if (sel) begin ice_b = e; iaddr_b = a; end
    else     begin ice_a = e; iaddr_a = a; end
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while (done_cnt < target && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (done_cnt < target) begin
      total_cnt++;
      $display("FAIL delivery_timeout: got %0d deliveries, want %0d", done_cnt, target);
    end
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] want, input int st);
    int target;
    target = done_cnt + 1;
    exp_inst_q.push_back(want);
    exp_stall_q.push_back(st);
    set_in(1'b1, a);
    wait_done(target);
    set_in(1'b0, a);
  endtask

  task automatic exp_addrs(input int a0, input int a1);
    exp_addr_q.push_back(a0);
    exp_addr_q.push_back(a1);
  endtask

  initial begin
    int target;
    foreach (mem[i]) mem[i] = 16'h0;
    mem[0] = 16'h1234; mem[1] = 16'hABCD;
    mem[2] = 16'h5678; mem[3] = 16'h9ABC;
    mem[4] = 16'hBEEF; mem[5] = 16'hDEAD;
    mem[8] = 16'h3C3C; mem[9] = 16'hC3C3;
    sel = 1'b0;
    rst_n = 1'b0;
    ice_a = 1'b1; iaddr_a = 32'h0;
    ice_b = 1'b0; iaddr_b = 32'h0;

    // Reset values with a fetch request pending.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ce_n", {31'b0, ce_n_a}, 32'h1);
    chk("rst_oe_n", {31'b0, oe_n_a}, 32'h1);
    chk("rst_addr", {12'b0, addr_a}, 32'h0);
    chk("rst_ce_n_b", {31'b0, ce_n_b}, 32'h1);
    ice_a = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // WAIT_CYCLES=2: miss costs 7 stall cycles, hits are free and leave the SRAM alone.
    exp_addrs(0, 1);
    fetch(32'h0000_0000, 32'hABCD1234, 7);
    fetch(32'h0000_0000, 32'hABCD1234, 0);
    fetch(32'h0000_0003, 32'hABCD1234, 0);
    exp_addrs(2, 3);
    fetch(32'h0000_0004, 32'h9ABC5678, 7);
    exp_addrs(0, 1);
    fetch(32'h0000_0000, 32'hABCD1234, 7);
    // Same SRAM word, different upper tag bits: must miss.
    exp_addrs(0, 1);
    fetch(32'h0020_0000, 32'hABCD1234, 7);
    exp_addrs(0, 1);
    fetch(32'h0000_0000, 32'hABCD1234, 7);

    // Address moves from 0x8 to 0x10 during HI: the 0x8 fill finishes, then 0x10 refills.
    exp_addrs(4, 5);
    exp_addrs(8, 9);
    exp_inst_q.push_back(32'hC3C33C3C);
    exp_stall_q.push_back(14);
    target = done_cnt + 1;
    set_in(1'b1, 32'h8);
    repeat (5) @(posedge clk);
    #1;
    set_in(1'b1, 32'h10);
    wait_done(target);
    set_in(1'b0, 32'h10);
    fetch(32'h0000_0010, 32'hC3C33C3C, 0);

    // Reset pulse in the middle of LO: outputs drop at once, the refetch misses.
    exp_addr_q.push_back(2);
    set_in(1'b1, 32'h4);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_stall", {31'b0, stall_a}, 32'h0);
    chk("midrst_inst", inst_a, 32'h0);
    chk("midrst_ce_n", {31'b0, ce_n_a}, 32'h1);
    chk("midrst_oe_n", {31'b0, oe_n_a}, 32'h1);
    chk("midrst_addr", {12'b0, addr_a}, 32'h0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    exp_addrs(2, 3);
    exp_inst_q.push_back(32'h9ABC5678);
    exp_stall_q.push_back(7);
    target = done_cnt + 1;
    wait_done(target);
    set_in(1'b0, 32'h4);
    fetch(32'h0000_0004, 32'h9ABC5678, 0);

    // WAIT_CYCLES=0: drop ice during LO and HI, fill still completes and then hits.
    @(posedge clk); #1;
    sel = 1'b1;
    @(posedge clk); #1;
    exp_addrs(4, 5);
    set_in(1'b1, 32'h8);
    @(posedge clk); #1;
    set_in(1'b0, 32'h8);
    @(negedge clk);
    chk("b_lo_ice0_stall", {31'b0, stall_b}, 32'h0);
    chk("b_lo_ice0_inst", inst_b, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    fetch(32'h0000_0008, 32'hDEADBEEF, 1);
    exp_addrs(0, 1);
    fetch(32'h0000_0000, 32'hABCD1234, 3);
    fetch(32'h0000_0000, 32'hABCD1234, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("exp_inst_q_empty", exp_inst_q.size(), 32'd0);
    chk("exp_addr_q_empty", exp_addr_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
